// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with start/parity/stop validation, feeding a
// two-entry FIFO read through a valid/ack handshake.
module uart_rx_fifo #(
  parameter int OSR  = 16,
  parameter int DIVW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rxd,
  input  logic            i_en,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_par_en,
  input  logic            i_par_odd,
  input  logic            i_ack,
  input  logic            i_clr_err,
  output logic [7:0]      o_dat,
  output logic            o_vld,
  output logic            o_full,
  output logic            o_ferr,
  output logic            o_perr,
  output logic            o_ovr,
  output logic            o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  localparam int            PW      = $clog2(OSR);
  localparam logic [PW-1:0] HALF_M1 = PW'(OSR / 2 - 1);
  localparam logic [PW-1:0] FULL_M1 = PW'(OSR - 1);

  state_t          state, state_nx;
  logic            sync1, sync2;
  logic [2:0]      maj_sr;
  logic            rxf, rxf_q;
  logic [DIVW-1:0] div_m1, tick_cnt;
  logic            tick, sample, start_det, start_mid;
  logic [PW-1:0]   phase;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            bad;
  logic            push, ferr_set, perr_set;

  logic [7:0]      mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      cnt;
  logic            pop, wr_ok, ovr_set;

  // Input conditioning: two-flop synchroniser, then a majority vote over
  // three tick-spaced samples so a single bad sample never reaches the FSM.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      maj_sr <= 3'b111;
      rxf_q  <= 1'b1;
    end else begin
      sync1 <= i_rxd;
      sync2 <= sync1;
      rxf_q <= rxf;
      if (tick) maj_sr <= {maj_sr[1:0], sync2};
    end
  end

  assign rxf = (maj_sr[0] & maj_sr[1]) | (maj_sr[0] & maj_sr[2]) | (maj_sr[1] & maj_sr[2]);

  // Tick generator; the >= compare keeps it sane if i_div shrinks mid-count.
  assign div_m1    = (i_div == '0) ? '0 : i_div - 1'b1;
  assign tick      = (tick_cnt >= div_m1);
  assign start_det = (state == S_IDLE) && i_en && rxf_q && !rxf;
  assign sample    = tick && (phase == FULL_M1);
  assign start_mid = tick && (state == S_START) && (phase == HALF_M1);

  always_ff @(posedge clk) begin
    if (rst)                    tick_cnt <= '0;
    else if (start_det || tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    unique case (state)
      S_IDLE:  if (start_det) state_nx = S_START;
      S_START: if (start_mid) state_nx = rxf ? S_IDLE : S_DATA;
      S_DATA:  if (sample && bit_cnt == 3'd7) state_nx = i_par_en ? S_PAR : S_STOP;
      S_PAR:   if (sample) state_nx = S_STOP;
      S_STOP: begin
        if (sample) begin
          if (rxf) begin
            state_nx = S_IDLE;
            perr_set = bad;
            push     = !bad;
          end else begin
            state_nx = S_BRK;
            ferr_set = 1'b1;
            perr_set = bad;
          end
        end
      end
      S_BRK:   if (rxf) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Disable aborts any frame without side effects.
    if (!i_en) begin
      state_nx = S_IDLE;
      push     = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      bad     <= 1'b0;
    end else if (state == S_IDLE) begin
      phase   <= '0;
      bit_cnt <= '0;
      bad     <= 1'b0;
    end else if (tick) begin
      phase <= (sample || start_mid) ? '0 : phase + 1'b1;
      if (sample && state == S_DATA) begin
        shreg   <= {rxf, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sample && state == S_PAR) bad <= ((^shreg) ^ rxf) != i_par_odd;
    end
  end

  // FIFO: a pop frees the head slot first, so push-while-full-with-pop fits.
  assign pop     = i_ack && (cnt != 2'd0);
  assign wr_ok   = push && ((cnt != 2'd2) || pop);
  assign ovr_set = push && (cnt == 2'd2) && !pop;

  // NOTE: the two storage entries are reset so o_dat is a defined 8'h00
  // out of reset rather than whatever the array powered up with.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky flags; a new error in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ferr <= 1'b0;
      o_perr <= 1'b0;
      o_ovr  <= 1'b0;
    end else begin
      o_ferr <= ferr_set | (o_ferr & ~i_clr_err);
      o_perr <= perr_set | (o_perr & ~i_clr_err);
      o_ovr  <= ovr_set  | (o_ovr  & ~i_clr_err);
    end
  end

  assign o_dat  = mem[rd_ptr];
  assign o_vld  = (cnt != 2'd0);
  assign o_full = (cnt == 2'd2);
  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo; frame outcomes are
// predicted from the line protocol rules with a queue model of the FIFO.
module tb_uart_rx_fifo;
  localparam int OSR  = 16;
  localparam int DIVW = 12;
  localparam int BIT3 = OSR * 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_rxd, i_en, i_par_en, i_par_odd, i_ack, i_clr_err;
  logic [DIVW-1:0] i_div;
  logic [7:0]      o_dat;
  logic            o_vld, o_full, o_ferr, o_perr, o_ovr, o_busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mq[$];
  bit   m_ferr, m_perr, m_ovr;

  uart_rx_fifo #(.OSR(OSR), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .i_rxd(i_rxd), .i_en(i_en), .i_div(i_div),
    .i_par_en(i_par_en), .i_par_odd(i_par_odd), .i_ack(i_ack),
    .i_clr_err(i_clr_err), .o_dat(o_dat), .o_vld(o_vld), .o_full(o_full),
    .o_ferr(o_ferr), .o_perr(o_perr), .o_ovr(o_ovr), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // All stimulus changes land 1 time unit after a rising edge.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stop_v, input int bclk);
    i_rxd = 1'b0;
    wait_clk(bclk);
    for (int i = 0; i < 8; i++) begin
      i_rxd = d[i];
      wait_clk(bclk);
    end
    if (pen) begin
      i_rxd = pbit;
      wait_clk(bclk);
    end
    i_rxd = stop_v;
    wait_clk(bclk);
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1;
    wait_clk(1);
    i_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    i_clr_err = 1'b1;
    wait_clk(1);
    i_clr_err = 1'b0;
  endtask

  // Stop-bit midpoint: half a bit for the start check, then nine (or ten with
  // parity) whole bits, counted from the first tick after the start edge.
  function automatic int push_clk(input bit pen, input int div_eff);
    return (OSR / 2 + OSR * (9 + int'(pen))) * div_eff;
  endfunction

  task automatic timed_push(input int t_clk, input bit do_ack, input bit chk_vld);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      wait_clk(1);
      if (o_busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("busy_rise", seen, 1);
    if (seen) begin
      wait_clk(t_clk - 1);
      if (chk_vld) check("vld_before_push", o_vld, 0);
      i_ack = do_ack;
      wait_clk(1);
      i_ack = 1'b0;
      if (chk_vld) check("vld_after_push", o_vld, 1);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_vld"}, o_vld, (mq.size() != 0));
    check({tag, "_full"}, o_full, (mq.size() == 2));
    if (mq.size() != 0) check({tag, "_dat"}, o_dat, mq[0]);
    check({tag, "_ferr"}, o_ferr, m_ferr);
    check({tag, "_perr"}, o_perr, m_perr);
    check({tag, "_ovr"}, o_ovr, m_ovr);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; i_rxd = 1'b1; i_en = 1'b0; i_div = DIVW'(3);
    i_par_en = 1'b0; i_par_odd = 1'b0; i_ack = 1'b0; i_clr_err = 1'b0;
    wait_clk(3);
    check("rst_dat", o_dat, 8'h00);
    check("rst_flags", {o_vld, o_full, o_ferr, o_perr, o_ovr, o_busy}, 6'b0);
    rst = 1'b0;
    i_en = 1'b1;
    wait_clk(2 * BIT3);

    // 1: single byte with exact push latency
    fork
      send_frame(8'hA5, 0, 0, 1, BIT3);
      timed_push(push_clk(0, 3), 0, 1);
    join
    check("t1_dat", o_dat, 8'hA5);
    check("t1_flags", {o_ferr, o_perr, o_ovr, o_full}, 4'b0);
    pulse_ack();
    check("t1_ack_empty", o_vld, 0);
    wait_clk(BIT3);

    // 2: three back-to-back frames, no ack
    send_frame(8'h11, 0, 0, 1, BIT3);
    send_frame(8'h22, 0, 0, 1, BIT3);
    send_frame(8'h33, 0, 0, 1, BIT3);
    wait_clk(2 * BIT3);
    check("t2_full", o_full, 1);
    check("t2_ovr", o_ovr, 1);
    check("t2_head0", o_dat, 8'h11);
    pulse_ack();
    check("t2_head1", o_dat, 8'h22);
    check("t2_not_full", o_full, 0);
    pulse_ack();
    check("t2_empty", o_vld, 0);

    // 3: ack lands in the stop-sample cycle of the third byte
    pulse_clr();
    check("t3_ovr_clr", o_ovr, 0);
    send_frame(8'h11, 0, 0, 1, BIT3);
    send_frame(8'h22, 0, 0, 1, BIT3);
    wait_clk(2 * BIT3);
    check("t3_pre_full", o_full, 1);
    fork
      send_frame(8'h33, 0, 0, 1, BIT3);
      timed_push(push_clk(0, 3), 1, 0);
    join
    wait_clk(BIT3);
    check("t3_ovr", o_ovr, 0);
    check("t3_full", o_full, 1);
    check("t3_head0", o_dat, 8'h22);
    pulse_ack();
    check("t3_head1", o_dat, 8'h33);
    pulse_ack();
    check("t3_empty", o_vld, 0);

    // 4: odd parity
    i_par_en = 1'b1; i_par_odd = 1'b1;
    wait_clk(BIT3);
    send_frame(8'h07, 1, 0, 1, BIT3);
    wait_clk(2 * BIT3);
    check("t4_good_vld", o_vld, 1);
    check("t4_good_dat", o_dat, 8'h07);
    check("t4_good_perr", o_perr, 0);
    pulse_ack();
    send_frame(8'h07, 1, 1, 1, BIT3);
    wait_clk(2 * BIT3);
    check("t4_bad_vld", o_vld, 0);
    check("t4_bad_perr", o_perr, 1);
    check("t4_bad_ferr", o_ferr, 0);
    pulse_clr();
    check("t4_perr_clr", o_perr, 0);
    i_par_en = 1'b0; i_par_odd = 1'b0;
    wait_clk(BIT3);

    // 5: bad stop bit, then a long break
    send_frame(8'h3C, 0, 0, 0, BIT3);
    wait_clk(BIT3);
    check("t5_ferr", o_ferr, 1);
    check("t5_busy_low", o_busy, 1);
    check("t5_vld", o_vld, 0);
    i_rxd = 1'b1;
    wait_clk(2 * BIT3);
    check("t5_busy_high", o_busy, 0);
    pulse_clr();
    i_rxd = 1'b0;
    wait_clk(12 * BIT3);
    check("t5_brk_ferr", o_ferr, 1);
    pulse_clr();
    wait_clk(8 * BIT3 - 1);
    check("t5_brk_single", o_ferr, 0);
    check("t5_brk_busy", o_busy, 1);
    i_rxd = 1'b1;
    wait_clk(2 * BIT3);
    check("t5_brk_end_busy", o_busy, 0);
    check("t5_brk_vld", o_vld, 0);
    check("t5_brk_ferr_end", o_ferr, 0);

    // 6a: one-tick glitch is filtered out
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 10) i_rxd = 1'b0;
      if (i == 13) i_rxd = 1'b1;
      wait_clk(1);
      seen |= o_busy;
    end
    check("t6_glitch_busy", seen, 0);

    // 6b: short low pulse is a false start
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 10) i_rxd = 1'b0;
      if (i == 10 + OSR / 4 * 3) i_rxd = 1'b1;
      wait_clk(1);
      seen |= o_busy;
    end
    check("t6_false_start_seen", seen, 1);
    check("t6_false_start_idle", o_busy, 0);
    check("t6_false_start_flags", {o_vld, o_ferr, o_perr, o_ovr}, 4'b0);

    // 6c: disable mid-frame keeps FIFO contents
    send_frame(8'h5A, 0, 0, 1, BIT3);
    wait_clk(2 * BIT3);
    check("t6_pre_dat", o_dat, 8'h5A);
    fork
      send_frame(8'h81, 0, 0, 1, BIT3);
      begin
        wait_clk(4 * BIT3);
        check("t6_in_frame", o_busy, 1);
        i_en = 1'b0;
        wait_clk(1);
        check("t6_abort_idle", o_busy, 0);
      end
    join
    wait_clk(2 * BIT3);
    check("t6_keep_vld", o_vld, 1);
    check("t6_keep_dat", o_dat, 8'h5A);
    check("t6_keep_state", {o_full, o_ferr, o_perr, o_ovr}, 4'b0);
    i_en = 1'b1;
    wait_clk(2 * BIT3);
    pulse_ack();
    check("t6_empty", o_vld, 0);

    // 7: randomized frames against the queue model
    mq.delete();
    m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    for (int f = 0; f < 14; f++) begin
      int         dv, bclk, n_ack;
      logic [7:0] d;
      bit         pen, podd, pbad, sbad, pbit;
      dv   = $urandom_range(0, 4);
      bclk = OSR * ((dv == 0) ? 1 : dv);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbad = pen && ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 4) == 0);
      pbit = podd ^ (^d) ^ pbad;
      i_div = DIVW'(dv); i_par_en = pen; i_par_odd = podd;
      wait_clk(2 * bclk);
      send_frame(d, pen, pbit, !sbad, bclk);
      i_rxd = 1'b1;
      wait_clk(2 * bclk);
      if (sbad) begin
        m_ferr = 1'b1;
        if (pbad) m_perr = 1'b1;
      end else if (pbad) begin
        m_perr = 1'b1;
      end else if (mq.size() == 2) begin
        m_ovr = 1'b1;
      end else begin
        mq.push_back(d);
      end
      check_model("rnd");
      n_ack = $urandom_range(0, 2);
      for (int a = 0; a < n_ack; a++) begin
        pulse_ack();
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      end
      check_model("rnd_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
